// File: rtl/vga_tile_fb.sv
`timescale 1ns/1ps
// 1bpp tiled VGA framebuffer: host/clear writes into a dual-port word RAM, pixel read pipe.
// Pixel out 3 cycles after coordinates; wr_ready drops for the whole clear fill.
module vga_tile_fb #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int WORD_W = 32,
   parameter int TILE_H = 4,
   localparam int DEPTH = H_RES * V_RES / WORD_W,
   localparam int AW    = $clog2(DEPTH),
   localparam int XW    = $clog2(H_RES),
   localparam int YW    = $clog2(V_RES)
) (
   input  logic              CLK_25,
   input  logic              Reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              clr_start,
   input  logic [WORD_W-1:0] clr_pattern,
   output logic              clr_busy,
   input  logic [XW-1:0]     pix_x,
   input  logic [YW-1:0]     pix_y,
   input  logic              pix_en,
   output logic              pix_out,
   output logic              pix_valid
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   localparam int BIW    = $clog2(WORD_W);
   localparam int BPW_LG = $clog2(WORD_W / 8);
   localparam int TH_LG  = $clog2(TILE_H);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [31:0]   ROW_BYTES = 32'(H_RES / 8 * TILE_H);
   localparam logic [31:0]   TH_MASK   = 32'(TILE_H - 1);
   localparam logic [31:0]   BPW_MASK  = 32'(WORD_W / 8 - 1);
   localparam logic [31:0]   H_LIM     = 32'(H_RES);
   localparam logic [31:0]   V_LIM     = 32'(V_RES);

   logic [WORD_W-1:0] mem [0:DEPTH-1];

   logic [0:0]        state;
   logic [AW-1:0]     clrCnt;
   logic [WORD_W-1:0] clrPat;

   logic              memWe;
   logic [AW-1:0]     memWa;
   logic [WORD_W-1:0] memWd;

   logic [XW-1:0]     xQ1;
   logic [YW-1:0]     yQ1;
   logic              enQ1;
   logic [31:0]       byteAddr;
   logic [AW-1:0]     wordAddr;
   logic [BIW-1:0]    bitIdx;
   logic              inRange;
   logic [AW-1:0]     addrQ2;
   logic [BIW-1:0]    bitQ2;
   logic              liveQ2;
   logic              validQ2;

   assign wr_ready = ~Reset & (state == IDLE);
   assign clr_busy = (state == CLEAR);

   always_ff @(posedge CLK_25 or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         clrCnt <= '0;
         clrPat <= '0;
      end else if (state == IDLE) begin
         if (clr_start) begin
            state  <= CLEAR;
            clrCnt <= '0;
            clrPat <= clr_pattern;
         end
      end else begin
         // Compare against the last address explicitly; DEPTH is rarely a power of two.
         if (clrCnt == LAST_ADDR) begin
            state <= IDLE;
         end else begin
            clrCnt <= clrCnt + AW'(1);
         end
      end
   end

   always_comb begin
      memWe = 1'b0;
      memWa = wr_addr;
      memWd = wr_data;
      if (state == CLEAR) begin
         memWe = ~Reset;
         memWa = clrCnt;
         memWd = clrPat;
      end else begin
         memWe = wr_valid & wr_ready & (wr_addr <= LAST_ADDR);
      end
   end

   always_ff @(posedge CLK_25) begin
      if (memWe) begin
         mem[memWa] <= memWd;
      end
   end

   // Tile layout: TILE_H consecutive bytes are the same 8-pixel column on successive lines.
   always_comb begin
      byteAddr = ((32'(yQ1) >> TH_LG) * ROW_BYTES)
               + ((32'(xQ1) >> 3) << TH_LG)
               + (32'(yQ1) & TH_MASK);
      wordAddr = AW'(byteAddr >> BPW_LG);
      bitIdx   = BIW'(((byteAddr & BPW_MASK) << 3) + (32'd7 - 32'(xQ1[2:0])));
      inRange  = (32'(xQ1) < H_LIM) && (32'(yQ1) < V_LIM);
   end

   always_ff @(posedge CLK_25 or posedge Reset) begin
      if (Reset) begin
         xQ1       <= '0;
         yQ1       <= '0;
         enQ1      <= 1'b0;
         addrQ2    <= '0;
         bitQ2     <= '0;
         liveQ2    <= 1'b0;
         validQ2   <= 1'b0;
         pix_out   <= 1'b0;
         pix_valid <= 1'b0;
      end else begin
         xQ1       <= pix_x;
         yQ1       <= pix_y;
         enQ1      <= pix_en;
         addrQ2    <= inRange ? wordAddr : '0;
         bitQ2     <= bitIdx;
         liveQ2    <= enQ1 & inRange;
         validQ2   <= enQ1;
         // Read-first: a word written at this same edge still returns its old value here.
         pix_out   <= liveQ2 ? mem[addrQ2][bitQ2] : 1'b0;
         pix_valid <= validQ2;
      end
   end

endmodule

// File: tb/tb_vga_tile_fb.sv
`timescale 1ns/1ps
// Directed bench for vga_tile_fb at default geometry (640x480, 32-bit words, 4-line tiles).
module tb_vga_tile_fb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrValid;
   logic        wrReady;
   logic [13:0] wrAddr;
   logic [31:0] wrData;
   logic        clrStart;
   logic [31:0] clrPattern;
   logic        clrBusy;
   logic [9:0]  pixX;
   logic [8:0]  pixY;
   logic        pixEn;
   logic        pixOut;
   logic        pixValid;

   int testsRun    = 0;
   int testsFailed = 0;

   vga_tile_fb dut (
      .CLK_25      (clk),
      .Reset       (rst),
      .wr_valid    (wrValid),
      .wr_ready    (wrReady),
      .wr_addr     (wrAddr),
      .wr_data     (wrData),
      .clr_start   (clrStart),
      .clr_pattern (clrPattern),
      .clr_busy    (clrBusy),
      .pix_x       (pixX),
      .pix_y       (pixY),
      .pix_en      (pixEn),
      .pix_out     (pixOut),
      .pix_valid   (pixValid)
   );

   always #20 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic readPix(input int x, input int y, input logic en,
                          input logic expOut, input logic expValid, input string tag);
      pixX  = 10'(x);
      pixY  = 9'(y);
      pixEn = en;
      tick;
      pixEn = 1'b0;
      tick;
      tick;
      checkVal({tag, ".out"}, 64'(pixOut), 64'(expOut));
      checkVal({tag, ".vld"}, 64'(pixValid), 64'(expValid));
   endtask

   task automatic writeWord(input int addr, input logic [31:0] data, input string tag);
      wrValid = 1'b1;
      wrAddr  = 14'(addr);
      wrData  = data;
      checkVal({tag, ".rdy"}, 64'(wrReady), 64'd1);
      tick;
      wrValid = 1'b0;
   endtask

   task automatic doClear(input logic [31:0] pattern, input logic holdWrite, input string tag);
      int busyCnt;
      int rdyBad;
      clrPattern = pattern;
      clrStart   = 1'b1;
      tick;
      clrStart   = 1'b0;
      clrPattern = 32'h0;
      checkVal({tag, ".busyRise"}, 64'(clrBusy), 64'd1);
      if (holdWrite) begin
         wrValid = 1'b1;
         wrAddr  = 14'd5;
         wrData  = 32'h0;
      end
      busyCnt = 0;
      rdyBad  = 0;
      while (clrBusy && busyCnt < 20000) begin
         busyCnt++;
         if (wrReady) rdyBad++;
         tick;
      end
      checkVal({tag, ".duration"}, 64'(busyCnt), 64'd9600);
      checkVal({tag, ".rdyLow"}, 64'(rdyBad), 64'd0);
      checkVal({tag, ".rdyBack"}, 64'(wrReady), 64'd1);
      if (holdWrite) begin
         tick;
         wrValid = 1'b0;
      end
   endtask

   // One pixel per tile; tiles map 1:1 to words at this geometry.
   task automatic scanTiles(input int expOnes);
      int ones;
      int valids;
      int tx;
      int ty;
      ones   = 0;
      valids = 0;
      for (int i = 0; i < 9602; i++) begin
         if (i < 9600) begin
            ty    = i / 80;
            tx    = i % 80;
            pixX  = 10'(8 * tx + ((tx + ty) % 8));
            pixY  = 9'(4 * ty + (tx % 4));
            pixEn = 1'b1;
         end else begin
            pixEn = 1'b0;
         end
         tick;
         if (pixValid) begin
            valids++;
            if (pixOut) ones++;
         end
      end
      checkVal("scan.valids", 64'(valids), 64'd9600);
      checkVal("scan.ones", 64'(ones), 64'(expOnes));
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      wrValid    = 1'b0;
      wrAddr     = '0;
      wrData     = '0;
      clrStart   = 1'b0;
      clrPattern = '0;
      pixX       = '0;
      pixY       = '0;
      pixEn      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkVal("rst.rdy", 64'(wrReady), 64'd0);
      checkVal("rst.busy", 64'(clrBusy), 64'd0);
      checkVal("rst.out", 64'(pixOut), 64'd0);
      checkVal("rst.vld", 64'(pixValid), 64'd0);
      rst = 1'b0;
      #1;
      checkVal("rel.rdy", 64'(wrReady), 64'd1);
      tick;

      doClear(32'h0000_0000, 1'b0, "clr0");

      writeWord(81, 32'h0000_0080, "w81a");
      pixX = 10'd8; pixY = 9'd4; pixEn = 1'b1;
      tick;
      pixEn = 1'b0;
      tick;
      checkVal("lat.early", 64'(pixValid), 64'd0);
      tick;
      checkVal("lat.out", 64'(pixOut), 64'd1);
      checkVal("lat.vld", 64'(pixValid), 64'd1);
      tick;
      checkVal("lat.vldDrop", 64'(pixValid), 64'd0);
      readPix(9, 4, 1'b1, 1'b0, 1'b1, "p9_4");
      readPix(8, 5, 1'b1, 1'b0, 1'b1, "p8_5");
      readPix(0, 0, 1'b1, 1'b0, 1'b1, "p0_0");
      readPix(8, 4, 1'b0, 1'b0, 1'b0, "p8_4off");

      writeWord(81, 32'h0000_8000, "w81b");
      readPix(8, 5, 1'b1, 1'b1, 1'b1, "t8_5");
      readPix(8, 4, 1'b1, 1'b0, 1'b1, "t8_4");

      writeWord(9599, 32'h0100_0000, "w9599");
      readPix(639, 479, 1'b1, 1'b1, 1'b1, "b639_479");
      readPix(638, 479, 1'b1, 1'b0, 1'b1, "b638_479");
      readPix(639, 476, 1'b1, 1'b0, 1'b1, "b639_476");
      writeWord(9600, 32'hFFFF_FFFF, "w9600");
      readPix(0, 0, 1'b1, 1'b0, 1'b1, "o0_0");
      readPix(639, 479, 1'b1, 1'b1, 1'b1, "o639_479");
      readPix(638, 479, 1'b1, 1'b0, 1'b1, "o638_479");
      readPix(640, 0, 1'b1, 1'b0, 1'b1, "oor640");

      // Word 81 is 0x8000 here, so (8,4) is 0 until the colliding write lands.
      pixX = 10'd8; pixY = 9'd4; pixEn = 1'b1;
      tick;
      tick;
      pixEn   = 1'b0;
      wrValid = 1'b1; wrAddr = 14'd81; wrData = 32'h0000_0080;
      tick;
      wrValid = 1'b0;
      checkVal("coll.old", 64'(pixOut), 64'd0);
      checkVal("coll.oldVld", 64'(pixValid), 64'd1);
      tick;
      checkVal("coll.new", 64'(pixOut), 64'd1);

      doClear(32'hFFFF_FFFF, 1'b1, "clr1");
      readPix(40, 0, 1'b1, 1'b0, 1'b1, "held5");
      readPix(48, 0, 1'b1, 1'b1, 1'b1, "word6");
      scanTiles(9599);

      clrPattern = 32'h0;
      clrStart   = 1'b1;
      tick;
      clrStart   = 1'b0;
      checkVal("mid.busy", 64'(clrBusy), 64'd1);
      pixX = 10'd0; pixY = 9'd0; pixEn = 1'b1;
      repeat (100) tick;
      checkVal("mid.preVld", 64'(pixValid), 64'd1);
      rst   = 1'b1;
      pixEn = 1'b0;
      #1;
      checkVal("mid.busyOff", 64'(clrBusy), 64'd0);
      checkVal("mid.rdyOff", 64'(wrReady), 64'd0);
      checkVal("mid.vldOff", 64'(pixValid), 64'd0);
      checkVal("mid.outOff", 64'(pixOut), 64'd0);
      tick;
      tick;
      rst = 1'b0;
      #1;
      checkVal("mid.rdyBack", 64'(wrReady), 64'd1);
      checkVal("mid.idle", 64'(clrBusy), 64'd0);
      tick;
      readPix(152, 4, 1'b1, 1'b0, 1'b1, "mid.w99");
      readPix(160, 4, 1'b1, 1'b1, 1'b1, "mid.w100");
      readPix(0, 0, 1'b1, 1'b0, 1'b1, "mid.w0");
      readPix(639, 479, 1'b1, 1'b1, 1'b1, "mid.w9599");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
